// File: rtl/score_bcd_scheduler.sv
// ============================================================================
// Module   : score_bcd_scheduler
// Purpose  : Score/high-score tracking, iterative double-dabble BCD conversion
//            and 8-digit multiplexed active-low 7-segment scan.
// Options  : LEADING_ZERO_BLANK_EN - blank leading zeros in each 4-digit group
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_bcd_scheduler #(
  parameter int SCORE_W  = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] current_score,
  input  logic               score_valid,
  input  logic               clear_high,
  output logic               busy,
  output logic [SCORE_W-1:0] high_score,
  output logic [6:0]         seg,
  output logic [7:0]         an
);

  localparam int                 CNT_W      = $clog2(SCORE_W) + 1;
  localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(SCORE_W - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE  = SCORE_W'(9999);
  localparam int                 SCAN_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV_CUR  = 2'd1,
    CONV_HIGH = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic               accept;
  logic               last_shift;
  logic [SCORE_W-1:0] sat_in;
  logic [SCORE_W-1:0] accept_score;
  logic [SCORE_W-1:0] high_reg;
  logic               pending;
  logic [SCORE_W-1:0] pend_score;

  logic [15:0]        bcd_sr;
  logic [SCORE_W-1:0] bin_sr;
  logic [CNT_W-1:0]   shift_cnt;
  logic [15:0]        bcd_adj;
  logic [15:0]        bcd_nxt;
  logic [SCORE_W-1:0] bin_nxt;
  logic [15:0]        cur_bcd;

  logic [31:0]        digits;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         digit_idx;
  logic [3:0]         cur_digit;
  logic [7:0]         blank;

  assign sat_in       = (current_score > MAX_SCORE) ? MAX_SCORE : current_score;
  assign accept_score = pending ? pend_score : sat_in;
  assign last_shift   = (shift_cnt == LAST_SHIFT);
  assign busy         = (state != IDLE);
  assign high_score   = high_reg;

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (pending || score_valid) begin
          accept    = 1'b1;
          state_nxt = CONV_CUR;
        end
      end
      CONV_CUR: begin
        if (last_shift) begin
          state_nxt = CONV_HIGH;
        end
      end
      CONV_HIGH: begin
        if (last_shift) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Double-dabble step: add 3 to every nibble >= 5, then shift left by one
  // ------------------------------------------------------------------------
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
    bcd_nxt = {bcd_adj[14:0], bin_sr[SCORE_W-1]};
    bin_nxt = {bin_sr[SCORE_W-2:0], 1'b0};
  end

  // ------------------------------------------------------------------------
  // Request slot and high score
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      pend_score <= '0;
      high_reg   <= '0;
    end else begin
      // A request that cannot be taken this edge parks in the slot; the
      // newest one overwrites anything already waiting.
      if (score_valid && (busy || pending)) begin
        pending    <= 1'b1;
        pend_score <= sat_in;
      end else if (accept) begin
        pending    <= 1'b0;
      end

      if (accept) begin
        if (clear_high || (accept_score > high_reg)) begin
          high_reg <= accept_score;
        end
      end else if (clear_high) begin
        high_reg <= '0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Conversion datapath and display registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_sr    <= '0;
      bin_sr    <= '0;
      shift_cnt <= '0;
      cur_bcd   <= '0;
      digits    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bin_sr    <= accept_score;
            bcd_sr    <= '0;
            shift_cnt <= '0;
          end
        end
        CONV_CUR: begin
          if (last_shift) begin
            // high_reg already reflects the accepted score at this point
            cur_bcd   <= bcd_nxt;
            bin_sr    <= high_reg;
            bcd_sr    <= '0;
            shift_cnt <= '0;
          end else begin
            bin_sr    <= bin_nxt;
            bcd_sr    <= bcd_nxt;
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end
        CONV_HIGH: begin
          bin_sr    <= bin_nxt;
          bcd_sr    <= bcd_nxt;
          shift_cnt <= shift_cnt + CNT_W'(1);
        end
        COMMIT: begin
          digits <= {bcd_sr, cur_bcd};
        end
        default: begin
          shift_cnt <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Digit scan
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_blank
      assign blank[4*g+3] = (digits[16*g+12 +: 4] == 4'd0);
      assign blank[4*g+2] = blank[4*g+3] && (digits[16*g+8 +: 4] == 4'd0);
      assign blank[4*g+1] = blank[4*g+2] && (digits[16*g+4 +: 4] == 4'd0);
      assign blank[4*g]   = 1'b0;
    end
  endgenerate
`else
  assign blank = 8'h00;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign cur_digit = digits[{digit_idx, 2'b00} +: 4];
  assign an        = ~(8'd1 << digit_idx);
  assign seg       = blank[digit_idx] ? 7'h7F : seg_decode(cur_digit);

endmodule

`default_nettype wire

// File: tb/tb_score_bcd_scheduler.sv
// ============================================================================
// Module   : tb_score_bcd_scheduler
// Purpose  : Directed self-checking bench for score_bcd_scheduler (SCAN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_bcd_scheduler;

  localparam int SCORE_W  = 14;
  localparam int SCAN_DIV = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [SCORE_W-1:0] current_score = '0;
  logic               score_valid = 1'b0;
  logic               clear_high = 1'b0;
  logic               busy;
  logic [SCORE_W-1:0] high_score;
  logic [6:0]         seg;
  logic [7:0]         an;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] disp_seg [8];
  logic [7:0] disp_seen;

  score_bcd_scheduler #(
    .SCORE_W  (SCORE_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .current_score (current_score),
    .score_valid   (score_valid),
    .clear_high    (clear_high),
    .busy          (busy),
    .high_score    (high_score),
    .seg           (seg),
    .an            (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected pattern of digit j given packed digits {d7..d0}
  function automatic logic [6:0] exp_seg(input int j, input logic [31:0] d);
    logic [15:0] grp;
    int          pos;
    grp = d[16*(j/4) +: 16];
    pos = j % 4;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && 16'(grp >> (4*pos)) == 16'd0) return 7'h7F;
`endif
    return seg_of(grp[4*pos +: 4]);
  endfunction

  task automatic pulse_score(input logic [SCORE_W-1:0] v);
    @(posedge clk); #1;
    current_score = v;
    score_valid   = 1'b1;
    @(posedge clk); #1;
    score_valid   = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic read_display();
    disp_seen = 8'h00;
    for (int j = 0; j < 8; j++) disp_seg[j] = 7'h00;
    repeat (40) begin
      @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        if (an == ~(8'd1 << j)) begin
          disp_seg[j]  = seg;
          disp_seen[j] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    vectors++;
    if (high_score !== '0) begin miscompares++; $display("FAIL reset_high got=%0d exp=0", high_score); end
    vectors++;
    if (an !== 8'hFE) begin miscompares++; $display("FAIL reset_an got=%h exp=fe", an); end
    vectors++;
    if (seg !== 7'h40) begin miscompares++; $display("FAIL reset_seg got=%h exp=40", seg); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 36; k++) begin
      logic [7:0] exp_an;
      #4;
      exp_an = ~(8'd1 << ((k / 4) % 8));
      vectors++;
      if (an !== exp_an) begin
        miscompares++;
        $display("FAIL scan_step k=%0d got=%h exp=%h", k, an, exp_an);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_convert(input logic [SCORE_W-1:0] v, input logic [SCORE_W-1:0] exp_high,
                              input logic [31:0] exp_digits);
    int n;
    pulse_score(v);
    count_busy(n);
    vectors++;
    if (n !== 29) begin miscompares++; $display("FAIL busy_len score=%0d got=%0d exp=29", v, n); end
    vectors++;
    if (high_score !== exp_high) begin
      miscompares++;
      $display("FAIL high score=%0d got=%0d exp=%0d", v, high_score, exp_high);
    end
    read_display();
    vectors++;
    if (disp_seen !== 8'hFF) begin miscompares++; $display("FAIL scan_cover got=%h exp=ff", disp_seen); end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (disp_seg[j] !== exp_seg(j, exp_digits)) begin
        miscompares++;
        $display("FAIL digit%0d score=%0d got=%h exp=%h", j, v, disp_seg[j], exp_seg(j, exp_digits));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       prev_busy;
    logic       gap_seen;
    logic [SCORE_W-1:0] gap_high;
    int         rises;
    logic       saw10;
    @(posedge clk); #1;
    clear_high = 1'b1;
    @(posedge clk); #1;
    clear_high = 1'b0;
    vectors++;
    if (high_score !== '0) begin miscompares++; $display("FAIL clear_idle got=%0d exp=0", high_score); end
    pulse_score(14'd5);
    repeat (2) @(posedge clk);
    pulse_score(14'd10);
    pulse_score(14'd20);
    prev_busy = 1'b1; gap_seen = 1'b0; gap_high = '0; rises = 0; saw10 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (high_score == 14'd10) saw10 = 1'b1;
      if (!busy && !gap_seen) begin gap_seen = 1'b1; gap_high = high_score; end
      if (!prev_busy && busy) rises++;
      prev_busy = busy;
    end
    vectors++;
    if (rises !== 1) begin miscompares++; $display("FAIL pending_convs got=%0d exp=1", rises); end
    vectors++;
    if (gap_high !== 14'd5) begin miscompares++; $display("FAIL pending_gap_high got=%0d exp=5", gap_high); end
    vectors++;
    if (saw10 !== 1'b0) begin miscompares++; $display("FAIL high_saw10 got=%0b exp=0", saw10); end
    vectors++;
    if (high_score !== 14'd20) begin miscompares++; $display("FAIL pending_high got=%0d exp=20", high_score); end
    read_display();
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (disp_seg[j] !== exp_seg(j, 32'h0020_0020)) begin
        miscompares++;
        $display("FAIL pend_digit%0d got=%h exp=%h", j, disp_seg[j], exp_seg(j, 32'h0020_0020));
      end
    end
  endtask

  task automatic test_clear_coincident();
    int n;
    pulse_score(14'd5000);
    count_busy(n);
    @(posedge clk); #1;
    current_score = 14'd300;
    score_valid   = 1'b1;
    clear_high    = 1'b1;
    @(posedge clk); #1;
    score_valid   = 1'b0;
    clear_high    = 1'b0;
    vectors++;
    if (high_score !== 14'd300) begin miscompares++; $display("FAIL clear_accept got=%0d exp=300", high_score); end
    count_busy(n);
    vectors++;
    if (n !== 29) begin miscompares++; $display("FAIL clear_busy_len got=%0d exp=29", n); end
    read_display();
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (disp_seg[j] !== exp_seg(j, 32'h0300_0300)) begin
        miscompares++;
        $display("FAIL clr_digit%0d got=%h exp=%h", j, disp_seg[j], exp_seg(j, 32'h0300_0300));
      end
    end
  endtask

  task automatic test_reset_abort();
    logic busy_seen;
    pulse_score(14'd800);
    pulse_score(14'd900);
    rst = 1'b1;
    #2;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    vectors++;
    if (high_score !== '0) begin miscompares++; $display("FAIL abort_high got=%0d exp=0", high_score); end
    @(posedge clk); #1;
    rst = 1'b0;
    busy_seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (busy) busy_seen = 1'b1;
    end
    vectors++;
    if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL abort_pending got=%0b exp=0", busy_seen); end
    read_display();
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (disp_seg[j] !== exp_seg(j, 32'h0000_0000)) begin
        miscompares++;
        $display("FAIL abort_digit%0d got=%h exp=%h", j, disp_seg[j], exp_seg(j, 32'h0000_0000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert(14'd1234,  14'd1234, 32'h1234_1234);
    test_convert(14'd567,   14'd1234, 32'h1234_0567);
    test_convert(14'd12000, 14'd9999, 32'h9999_9999);
    test_back_to_back();
    test_clear_coincident();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_bcd_scheduler.md
Name: score_bcd_scheduler

Overview:
- Controls the score display path. Accepts binary score updates and maintains the high score.
- Converts both values to BCD one at a time with an iterative double-dabble engine, instead of using parallel divide/modulo logic.
- Time-multiplexes the 8 resulting digits onto the active-low 7-segment display.
- Sits between game logic (score source) and the board's seg/anode pins.

Parameters:
- SCORE_W, 14, binary score width (9999 fits in 14 bits).
- SCAN_DIV, 100000, clk cycles each digit stays lit (must be >= 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- current_score  in  SCORE_W  binary score from game logic
- score_valid  in  1  single-cycle request: convert and display current_score
- clear_high  in  1  single-cycle request: zero the high score
- busy  out  1  conversion in progress
- high_score  out  SCORE_W  saturated high score, binary
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g
- an  out  8  active-low one-hot digit enable; an[k] drives digit k

Behaviour:
- Saturation: any accepted score > 9999 is treated as 9999 everywhere (conversion and high-score compare).
- Reset values (asynchronous, on rst=1):
  - FSM=IDLE, busy=0, pending=0, high_score=0.
  - All 8 display digit registers = 0.
  - Scan counter=0, digit index=0, so an=8'b1111_1110 and seg=7'b1000000.
- FSM states: IDLE, CONV_CUR, CONV_HIGH, COMMIT.
- IDLE:
  - On score_valid, or with pending=1, latch the saturated score (the pending value takes precedence when pending=1; pending is cleared).
  - On the same edge, high_score <= max(high_score, score); go to CONV_CUR.
- CONV_CUR:
  - SCORE_W cycles of shift-add-3 on a 16-bit BCD + SCORE_W-bit shift register.
  - The last shift edge stores the current-score BCD into a shadow register, reloads the shift register with high_score, and moves to CONV_HIGH.
- CONV_HIGH: SCORE_W cycles of shift-add-3, then go to COMMIT.
- COMMIT: one cycle. Copies both BCD results into the display digit registers on the same edge (digits 0-3 = current, digit 0 = units; digits 4-7 = high), then returns to IDLE.
- Latency and busy:
  - busy=1 for exactly 2*SCORE_W+1 cycles, starting the cycle after the accepting edge.
  - New digits are visible the cycle after COMMIT.
  - Display registers never show partial results.
- Requests while busy:
  - A score_valid while busy=1 is stored in a single-entry pending slot; a later request overwrites it (latest value wins).
  - The pending request is accepted in the first IDLE cycle after COMMIT, giving exactly one more conversion.
  - high_score does not change until the pending request is accepted.
- clear_high:
  - Sets high_score=0 on the next edge in any state.
  - If it coincides with an accepting edge, the result is high_score = accepted score.
  - A clear during CONV_HIGH does not alter the value already loaded for that conversion.
- Scan:
  - The counter counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count the digit index increments and wraps 7→0.
  - an = ~(1<<index); seg = decode of digit[index].
  - Decoder patterns 0-9 are standard active-low; codes 10-15 decode to blank (7'h7F).
- Reset mid-conversion aborts immediately; no partial commit, and pending is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- With the macro defined, each 4-digit group blanks (seg=7'h7F) leading zero digits above its units digit. Units digits always show.
  - Example: current 0042 shows as "  42".
- Without the macro, all 8 digits always display, including leading zeros.
- Blanking is evaluated combinationally from the committed digits and does not affect latency.

Test Plan:
- Reset with rst=1 mid-run → busy=0, high_score=0, an=8'hFE, seg=7'h40; with SCAN_DIV=4, an steps FE,FD,…,7F,FE every 4 cycles.
- score_valid with current_score=1234 → busy=1 for 29 cycles → digits[3:0]=1,2,3,4, digits[7:4]=1,2,3,4, high_score=1234.
- Then score 567 → current digits 0,5,6,7 and high stays 1234. With LEADING_ZERO_BLANK_EN, digit 3 seg=7'h7F.
- Score 12000 → saturated: current digits 9999, high_score=9999.
- While busy, pulse score_valid with 10 then 20 → exactly one extra conversion, showing 0020; high_score never observes 10.
- clear_high coincident with accepting 300 → high_score=300. Then assert rst during CONV_CUR of 800 → no commit, digits all 0.
